// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU ops, operand selects.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // True for the opcodes this controller knows how to sequence.
    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational strobe/select decode from FSM state and the opcode in effect (MC_CTRL_MEM_WAIT_EN adds memory waits).
// Latency: 0 cycles, purely combinational.
// Backpressure: with MC_CTRL_MEM_WAIT_EN, mem_go follows mem_ready and gates FETCH writes and MEM completion.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e      state,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_go,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_2_reg,
    output logic        reg_write,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal
);

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    // Memory is assumed single-cycle; the handshake input is deliberately dropped.
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_go           = 1'b1;
`endif

    // Per-state datapath strobes; everything defaults low so IDLE drives all zeros.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_2_reg  = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_go;
                pc_write  = mem_go;
            end
            S_DECODE: begin
                // Speculative branch target: old PC + immediate.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_ADD;
                if (!op_supported(opcode)) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_RS2;
                        alu_op    = ALU_RTYPE;
                    end
                    OP_ITYPE, OP_LOAD, OP_STORE: begin
                        alu_src_a = SRC_A_RS1;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        alu_src_a  = SRC_A_RS1;
                        alu_src_b  = SRC_B_RS2;
                        alu_op     = ALU_SUB;
                        branch     = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_JAL: begin
                        jump       = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (opcode == OP_STORE) begin
                    mem_write  = 1'b1;
                    instr_done = mem_go;
                end else begin
                    mem_read = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_2_reg  = (opcode == OP_LOAD);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB); MC_CTRL_MEM_WAIT_EN enables memory wait states.
// Latency: BEQ/JAL 3, R/I/SW 4, LW 5 cycles; illegal opcodes end in DECODE after 2.
// Backpressure: en is sampled only in IDLE and on instr_done; FETCH/MEM stall on mem_ready=0 when waits are enabled.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_2_reg,
    output logic        reg_write,
    output logic        branch,
    output logic        jump,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  state
);

    state_e     state_q, state_d;
    logic [6:0] opcode_q, opcode_d;
    logic [6:0] opcode_eff;
    logic       mem_go;

    // The opcode is only trusted live during DECODE; afterwards the latched copy rules.
    assign opcode_eff = (state_q == S_DECODE) ? opcode : opcode_q;
    assign state      = state_q;

    mc_ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (opcode_eff),
        .mem_ready  (mem_ready),
        .mem_go     (mem_go),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_2_reg  (mem_2_reg),
        .reg_write  (reg_write),
        .branch     (branch),
        .jump       (jump),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // Next state: instr_done always takes the end-of-instruction exit, otherwise walk the phases.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        if (state_q == S_DECODE) begin
            opcode_d = opcode;
        end
        if (instr_done) begin
            state_d = en ? S_FETCH : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (en) state_d = S_FETCH;
                S_FETCH:  if (mem_go) state_d = S_DECODE;
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    case (opcode_q)
                        OP_RTYPE, OP_ITYPE: state_d = S_WB;
                        OP_LOAD, OP_STORE:  state_d = S_MEM;
                        default:            state_d = S_IDLE;
                    endcase
                end
                S_MEM:    if (mem_go) state_d = S_WB;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // State and latched opcode; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be: none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 arst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  run enable; sampled in IDLE and on the last cycle of each instruction.
REQ-005 opcode  input  7  RISC-V opcode[6:0] from the instruction register.
REQ-006 mem_ready  input  1  memory access complete (used only when MC_CTRL_MEM_WAIT_EN is defined).
REQ-007 pc_write, ir_write, mem_read, mem_write, mem_2_reg, reg_write, branch, jump  output  1 each  datapath strobes.
REQ-008 alu_src_a  output  2  00=PC, 01=rs1, 10=old PC.
REQ-009 alu_src_b  output  2  00=rs2, 01=constant 4, 10=immediate.
REQ-010 alu_op  output  2  00=add, 01=sub, 10=R-type funct decode.
REQ-011 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode.
REQ-013 state  output  3  current FSM state, for debug.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-015 IDLE: all outputs SHALL be 0; go to FETCH when en=1, otherwise stay in IDLE.
REQ-016 FETCH: mem_read=1, alu_src_a=00, alu_src_b=01, alu_op=00, ir_write=1, pc_write=1; go to DECODE.
REQ-017 DECODE: latch opcode into an internal register; alu_src_a=10, alu_src_b=10, alu_op=00 (branch target); go to EXEC for supported opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111.
REQ-018 Unsupported opcode: pulse illegal and instr_done in DECODE, with no write strobes; then take the end-of-instruction transition (REQ-024).
REQ-019 EXEC for R-type: a=01, b=00, op=10; I-type/LW/SW: a=01, b=10, op=00; BEQ: a=01, b=00, op=01, branch=1; JAL: jump=1, pc_write=1.
REQ-020 From EXEC: R-type/I-type go to WB; LW/SW go to MEM; BEQ/JAL end the instruction (REQ-024).
REQ-021 MEM: mem_read=1 for LW, then go to WB; mem_write=1 for SW, then end the instruction.
REQ-022 WB: reg_write=1, with mem_2_reg=1 for LW only; then end the instruction.
REQ-023 Instruction latency SHALL be: BEQ/JAL 3 cycles, R/I/SW 4 cycles, LW 5 cycles (no wait states).
REQ-024 End of instruction: assert instr_done; next state FETCH if en=1, else IDLE.
REQ-025 en SHALL be ignored mid-instruction; an instruction always completes.
REQ-026 Outputs SHALL decode combinationally from the registered state and the latched opcode; opcode changes after DECODE SHALL have no effect.

Reset
REQ-027 arst_n=0 SHALL immediately force state=IDLE, clear the latched opcode, and drive all outputs to 0.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction without any further write strobe.

Configuration
REQ-029 With MC_CTRL_MEM_WAIT_EN defined, FETCH and MEM SHALL hold while mem_ready=0, keeping their read/write strobes asserted.
REQ-030 In those held states, ir_write/pc_write (FETCH) and the state advance SHALL occur only in the cycle where mem_ready=1.
REQ-031 With MC_CTRL_MEM_WAIT_EN undefined, mem_ready SHALL be ignored and FETCH/MEM SHALL last exactly one cycle.

Structure
REQ-032 A shared package mc_ctrl_pkg SHALL hold the state encoding, the opcode constants, the alu_op codes (ADD/SUB/R_TYPE), and the alu_src_a/b select constants.
REQ-033 A combinational sub-module mc_ctrl_decode (inputs: state, latched opcode, mem_ready; outputs: all strobes and selects) SHALL be used; multicycle_control holds only the state and opcode registers and the next-state logic.

Verification
REQ-034 Reset released with en=1 and opcode=0110011 -> IDLE, FETCH, DECODE, EXEC (alu_op=10), WB (reg_write=1, instr_done=1), FETCH.
REQ-035 opcode=0000011 -> 5 cycles; MEM has mem_read=1; WB has mem_2_reg=1 and reg_write=1.
REQ-036 opcode=1100011 -> EXEC has branch=1 and alu_op=01, instr_done in the same cycle, no reg_write at any point.
REQ-037 opcode=1111111 -> illegal=1 and instr_done=1 in DECODE, no write strobes, then FETCH.
REQ-038 With MC_CTRL_MEM_WAIT_EN defined, SW with mem_ready=0 for 3 cycles -> MEM lasts 4 cycles, mem_write held, exactly one instr_done.
REQ-039 en=0 asserted during EXEC of an R-type, and arst_n pulsed low during MEM of an LW -> the first instruction completes then goes to IDLE; the second sees all outputs 0 at once and never asserts reg_write.
